// File: rtl/gemm_c_requantizer_pkg.sv
// Shared definitions for the GEMM output path: default widths and the job FSM states.
package gemm_pkg;

  localparam int unsigned InDataWidth   = 8;
  localparam int unsigned OutDataWidth  = 32;
  localparam int unsigned ScaleWidth    = 16;
  localparam int unsigned ShiftWidth    = 5;
  localparam int unsigned AddrWidth     = 12;
  localparam int unsigned SizeAddrWidth = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/gemm_c_requantizer_if.sv
// Job control plus SRAM C read / SRAM Q write bundle for the C-matrix requantizer.
interface gemm_c_requantizer_if #(
  parameter int unsigned InDataWidth   = gemm_pkg::InDataWidth,
  parameter int unsigned OutDataWidth  = gemm_pkg::OutDataWidth,
  parameter int unsigned ScaleWidth    = gemm_pkg::ScaleWidth,
  parameter int unsigned ShiftWidth    = gemm_pkg::ShiftWidth,
  parameter int unsigned AddrWidth     = gemm_pkg::AddrWidth,
  parameter int unsigned SizeAddrWidth = gemm_pkg::SizeAddrWidth
);

  logic                     start_i;
  logic [SizeAddrWidth-1:0] M_size_i;
  logic [SizeAddrWidth-1:0] N_size_i;
  logic [ScaleWidth-1:0]    scale_i;
  logic [ShiftWidth-1:0]    shift_i;
  logic                     relu_en_i;
  logic [AddrWidth-1:0]     sram_c_addr_o;
  logic [OutDataWidth-1:0]  sram_c_rdata_i;
  logic [AddrWidth-1:0]     sram_q_addr_o;
  logic [InDataWidth-1:0]   sram_q_wdata_o;
  logic                     sram_q_we_o;
  logic                     done_o;

  // Requantizer side
  modport slave (
    input  start_i, M_size_i, N_size_i, scale_i, shift_i, relu_en_i, sram_c_rdata_i,
    output sram_c_addr_o, sram_q_addr_o, sram_q_wdata_o, sram_q_we_o, done_o
  );

  // Controller / memory side
  modport master (
    output start_i, M_size_i, N_size_i, scale_i, shift_i, relu_en_i, sram_c_rdata_i,
    input  sram_c_addr_o, sram_q_addr_o, sram_q_wdata_o, sram_q_we_o, done_o
  );

endinterface

// File: rtl/gemm_c_requantizer_requant_unit.sv
// Combinational requantization of a signed scaled product:
// round-half-up arithmetic right shift, optional ReLU, saturation to OutWidth.
module requant_unit #(
  parameter int unsigned ProdWidth  = 48,
  parameter int unsigned ShiftWidth = 5,
  parameter int unsigned OutWidth   = 8
) (
  input  logic signed [ProdWidth-1:0]  prod,
  input  logic        [ShiftWidth-1:0] shift,
  input  logic                         relu_en,
  output logic signed [OutWidth-1:0]   result
);

  // One extra bit keeps the product plus rounding constant from overflowing.
  localparam int unsigned SumWidth = ProdWidth + 1;
  localparam logic signed [SumWidth-1:0] MaxVal = SumWidth'((2 ** (OutWidth - 1)) - 1);
  localparam logic signed [SumWidth-1:0] MinVal = ~MaxVal;

  logic signed [SumWidth-1:0] bias;
  logic signed [SumWidth-1:0] sum;
  logic signed [SumWidth-1:0] shifted;
  logic signed [SumWidth-1:0] clipped;

  // Round, shift, rectify and saturate in one combinational pass
  always_comb begin
    bias = '0;
    if (shift != '0) begin
      bias[shift - ShiftWidth'(1)] = 1'b1;
    end
    sum     = SumWidth'(prod) + bias;
    shifted = sum >>> shift;
    clipped = shifted;
    if (relu_en && (shifted < 0)) begin
      clipped = '0;
    end
    if (clipped > MaxVal) begin
      result = MaxVal[OutWidth-1:0];
    end else if (clipped < MinVal) begin
      result = MinVal[OutWidth-1:0];
    end else begin
      result = clipped[OutWidth-1:0];
    end
  end

endmodule

// File: rtl/gemm_c_requantizer.sv
// Streams the int32 C matrix out of SRAM C after a GEMM job and writes the
// requantized int8 elements to SRAM Q at the same index, one per cycle.
module gemm_c_requantizer #(
  parameter int unsigned InDataWidth   = gemm_pkg::InDataWidth,
  parameter int unsigned OutDataWidth  = gemm_pkg::OutDataWidth,
  parameter int unsigned ScaleWidth    = gemm_pkg::ScaleWidth,
  parameter int unsigned ShiftWidth    = gemm_pkg::ShiftWidth,
  parameter int unsigned AddrWidth     = gemm_pkg::AddrWidth,
  parameter int unsigned SizeAddrWidth = gemm_pkg::SizeAddrWidth
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  gemm_c_requantizer_if.slave  bus
);

  import gemm_pkg::*;

  localparam int unsigned ProdWidth = OutDataWidth + ScaleWidth;
  localparam int unsigned TotWidth  = 2 * SizeAddrWidth;

  state_e state, state_next;

  logic [TotWidth-1:0]          total;
  logic                         job_empty;
  logic [AddrWidth-1:0]         rd_idx;
  logic [AddrWidth-1:0]         last_idx;
  logic                         issue_last;

  logic signed [ScaleWidth-1:0] scale_q;
  logic [ShiftWidth-1:0]        shift_q;
  logic                         relu_q;

  logic                         valid_rd;
  logic                         valid_wr;
  logic [AddrWidth-1:0]         idx_rd;
  logic [AddrWidth-1:0]         idx_wr;
  logic signed [ProdWidth-1:0]  rdata_ext;
  logic signed [ProdWidth-1:0]  scale_ext;
  logic signed [ProdWidth-1:0]  prod_q;

  assign total      = {{SizeAddrWidth{1'b0}}, bus.M_size_i} * {{SizeAddrWidth{1'b0}}, bus.N_size_i};
  assign job_empty  = (total == '0);
  assign issue_last = (rd_idx == last_idx);
  assign rdata_ext  = ProdWidth'($signed(bus.sram_c_rdata_i));
  assign scale_ext  = ProdWidth'(scale_q);

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DRAIN leaves once the read stage is empty, so the final
  // write retires in the last DRAIN cycle. An empty job passes through DRAIN
  // for one cycle, which places done two cycles after start.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_next = job_empty ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (issue_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!valid_rd) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Job parameter latch and read index counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_idx   <= '0;
      last_idx <= '0;
      scale_q  <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
    end else if ((state == IDLE) && bus.start_i) begin
      scale_q  <= $signed(bus.scale_i);
      shift_q  <= bus.shift_i;
      relu_q   <= bus.relu_en_i;
      // A count of exactly 2**AddrWidth truncates to 0 and wraps to the top index.
      last_idx <= total[AddrWidth-1:0] - AddrWidth'(1);
      if (!job_empty) begin
        rd_idx <= '0;
      end
    end else if ((state == RUN) && !issue_last) begin
      rd_idx <= rd_idx + AddrWidth'(1);
    end
  end

  // Two-stage valid/index pipeline and product register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_rd <= 1'b0;
      valid_wr <= 1'b0;
      idx_rd   <= '0;
      idx_wr   <= '0;
      prod_q   <= '0;
    end else begin
      valid_rd <= (state == RUN);
      idx_rd   <= rd_idx;
      valid_wr <= valid_rd;
      idx_wr   <= idx_rd;
      if (valid_rd) begin
        prod_q <= rdata_ext * scale_ext;
      end
    end
  end

  requant_unit #(
    .ProdWidth  (ProdWidth),
    .ShiftWidth (ShiftWidth),
    .OutWidth   (InDataWidth)
  ) u_requant (
    .prod    (prod_q),
    .shift   (shift_q),
    .relu_en (relu_q),
    .result  (bus.sram_q_wdata_o)
  );

  assign bus.sram_c_addr_o = rd_idx;
  assign bus.sram_q_addr_o = idx_wr;
  assign bus.sram_q_we_o   = valid_wr;
  assign bus.done_o        = (state == DONE);

endmodule

// File: tb/tb_gemm_c_requantizer.sv
// Directed bench for gemm_c_requantizer with a behavioural SRAM C and a
// scoreboard of expected SRAM Q writes.
module tb_gemm_c_requantizer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gemm_c_requantizer_if bus ();

  gemm_c_requantizer dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  int   mem_c [4096];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // SRAM C: one-cycle read latency
  always @(posedge clk) bus.sram_c_rdata_i <= mem_c[bus.sram_c_addr_o];

  function automatic logic [7:0] gold(input int c, input int sc, input int sh, input bit re);
    longint p;
    longint r;
    p = longint'(c) * longint'(sc);
    if (sh == 0) r = p;
    else r = (p + (longint'(1) << (sh - 1))) >>> sh;
    if (re && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_inputs();
    bus.M_size_i  = 8'($urandom);
    bus.N_size_i  = 8'($urandom);
    bus.scale_i   = 16'($urandom);
    bus.shift_i   = 5'($urandom);
    bus.relu_en_i = 1'($urandom);
  endtask

  task automatic run_job(input int m, input int n, input int sc, input int sh, input bit re,
                         input int abort_at, input bit mid_start);
    int   total, exp_done, c, writes, last_wr, first_wr;
    bit   seen_done, aborted;
    exp_t e;
    total    = m * n;
    exp_done = (total == 0) ? 2 : total + 3;
    sb.delete();
    for (int i = 0; i < total; i++) begin
      e.addr = 12'(i);
      e.data = gold(mem_c[i], sc, sh, re);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.M_size_i  = 8'(m);
    bus.N_size_i  = 8'(n);
    bus.scale_i   = 16'(sc);
    bus.shift_i   = 5'(sh);
    bus.relu_en_i = re;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    randomize_inputs();
    c = 0; writes = 0; last_wr = -1; first_wr = -1; seen_done = 1'b0; aborted = 1'b0;
    while (!seen_done && !aborted && c < exp_done + 20) begin
      @(negedge clk);
      c++;
      if (mid_start && c == 50) begin
        bus.start_i  = 1'b1;
        bus.M_size_i = 8'd1;
        bus.N_size_i = 8'd1;
      end
      if (mid_start && c == 51) bus.start_i = 1'b0;
      if (bus.sram_q_we_o === 1'b1) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_bad++;
          $error("FAIL spurious_write: observed write to %0h expected none", bus.sram_q_addr_o);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("q_addr", 64'(bus.sram_q_addr_o), 64'(e.addr));
          check("q_data", 64'(bus.sram_q_wdata_o), 64'(e.data));
          if (abort_at >= 0 && e.addr == 12'(abort_at)) begin
            rst_n = 1'b0;
            #1;
            check("abort_we", 64'(bus.sram_q_we_o), 64'd0);
            check("abort_c_addr", 64'(bus.sram_c_addr_o), 64'd0);
            check("abort_q_addr", 64'(bus.sram_q_addr_o), 64'd0);
            check("abort_wdata", 64'(bus.sram_q_wdata_o), 64'd0);
            check("abort_done", 64'(bus.done_o), 64'd0);
            for (int k = 0; k < 3; k++) begin
              @(negedge clk);
              check("abort_hold_we", 64'(bus.sram_q_we_o), 64'd0);
              check("abort_hold_done", 64'(bus.done_o), 64'd0);
            end
            rst_n = 1'b1;
            aborted = 1'b1;
          end
        end
        if (last_wr >= 0) check("write_gap", 64'(c - last_wr), 64'd1);
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        writes++;
      end
      if (!aborted && bus.done_o === 1'b1) begin
        seen_done = 1'b1;
        check("done_cycle", 64'(c), 64'(exp_done));
      end
    end
    if (!aborted) begin
      check("done_seen", 64'(seen_done), 64'd1);
      check("write_total", 64'(writes), 64'(total));
      check("sb_drained", 64'(sb.size()), 64'd0);
      if (total > 0) begin
        check("first_write_cycle", 64'(first_wr), 64'd3);
        check("c_addr_hold", 64'(bus.sram_c_addr_o), 64'(12'(total - 1)));
      end
      @(negedge clk);
      check("done_pulse_width", 64'(bus.done_o), 64'd0);
      check("idle_we", 64'(bus.sram_q_we_o), 64'd0);
    end
  endtask

  int t1 [6] = '{0, 1, -1, 100, -100, 7};
  int t2 [4] = '{1000, -1000, 200, -129};
  int t3 [4] = '{5, 6, -5, -6};
  int t4 [2] = '{-50, 50};

  initial begin
    bus.start_i   = 1'b0;
    bus.M_size_i  = '0;
    bus.N_size_i  = '0;
    bus.scale_i   = '0;
    bus.shift_i   = '0;
    bus.relu_en_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we", 64'(bus.sram_q_we_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_c_addr", 64'(bus.sram_c_addr_o), 64'd0);
    check("rst_q_addr", 64'(bus.sram_q_addr_o), 64'd0);
    check("rst_wdata", 64'(bus.sram_q_wdata_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pass-through at unit scale
    foreach (t1[i]) mem_c[i] = t1[i];
    run_job(2, 3, 1, 0, 1'b0, -1, 1'b0);

    // Saturation on both rails
    foreach (t2[i]) mem_c[i] = t2[i];
    run_job(2, 2, 1, 0, 1'b0, -1, 1'b0);

    // Round half up with arithmetic shift
    foreach (t3[i]) mem_c[i] = t3[i];
    run_job(1, 4, 1, 2, 1'b0, -1, 1'b0);

    // ReLU with scale and shift
    foreach (t4[i]) mem_c[i] = t4[i];
    run_job(1, 2, 3, 1, 1'b1, -1, 1'b0);

    // Empty jobs
    run_job(0, 5, 1, 0, 1'b0, -1, 1'b0);
    run_job(4, 0, 1, 0, 1'b0, -1, 1'b0);

    // Full 32x32 job: abort by reset, then a clean rerun with a stray start
    for (int i = 0; i < 1024; i++) begin
      if (i % 2 == 0) mem_c[i] = int'($urandom_range(0, 200000)) - 100000;
      else mem_c[i] = int'($urandom);
    end
    run_job(32, 32, -1234, 14, 1'b0, 100, 1'b0);
    repeat (2) @(negedge clk);
    run_job(32, 32, 123, 9, 1'b1, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
